mem_port_arbiter: RTL and testbench

// - Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
// - Runs a registered FSM and holds the memory command stable until the memory acknowledges.
// - Returns read data with a one-cycle done pulse to the winning requester.
// - Drives i_stall/d_stall into the hazard control unit, which freezes the IF/ID stage or the whole pipe.

---
 rtl/mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the IF stage (instruction fetch) and
// the MEM stage (load/store). A registered FSM (IDLE, BUSY_I, BUSY_D) grants
// the port, holds the memory command stable until mem_ready, and returns the
// read data with a one-cycle done pulse to the winning requester. The stall
// outputs feed the hazard control unit.
//
// Arbitration (IDLE only): D beats I unless I has waited through STARVE_LIMIT
// consecutive D grants. A requester whose done pulse is high this cycle is
// masked, so its still-asserted level request is not granted twice.
//
// Parameters
//   WORD_SIZE     width of address and data
//   STARVE_LIMIT  D grants allowed while IF waits (0 = strict D priority, max 7)
//
// Ports
//   clk, reset                      rising-edge clock, async active-high reset
//   i_req, i_addr                   IF fetch request (level) and address
//   i_done, i_rdata, i_stall        IF completion pulse, data, stall
//   d_read, d_write, d_addr,        MEM load/store request (level), address,
//   d_wdata                         store data (read+write = write)
//   d_done, d_rdata, d_stall        MEM completion pulse, load data, stall
//   mem_read, mem_write,            memory command, held until mem_ready
//   mem_addr, mem_wdata
//   mem_rdata, mem_ready            memory response (one-cycle ready)
//
// Configuration
//   MEM_PORT_ARB_STATS_EN           when defined, adds the 16-bit wrapping
//                                   counters stat_i_grants, stat_d_grants and
//                                   stat_conflicts as extra output ports.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  // IF requester
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_done,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_stall,
  // MEM requester
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_stall,
  // memory port
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [15:0]          stat_i_grants,
  output logic [15:0]          stat_d_grants,
  output logic [15:0]          stat_conflicts
`endif
);

  localparam int unsigned STREAK_W = 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic STARVE_ON = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t                r_state;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_i_done;
  logic                  r_d_done;
  logic [WORD_SIZE-1:0]  r_i_rdata;
  logic [WORD_SIZE-1:0]  r_d_rdata;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [WORD_SIZE-1:0]  r_mem_addr;
  logic [WORD_SIZE-1:0]  r_mem_wdata;

  logic w_idle;
  logic w_d_req;
  logic w_i_pend;
  logic w_d_pend;
  logic w_starve;
  logic w_grant_d;
  logic w_grant_i;

  // Request qualification: a requester in its done cycle is masked.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_d_req  = d_read | d_write;
  assign w_i_pend = i_req & ~r_i_done;
  assign w_d_pend = w_d_req & ~r_d_done;

  // IF has waited long enough; it overrides the default D priority once.
  assign w_starve  = STARVE_ON & w_i_pend & (r_streak == STREAK_MAX);
  assign w_grant_d = w_idle & w_d_pend & ~w_starve;
  assign w_grant_i = w_idle & w_i_pend & ~w_grant_d;

  // Arbitration FSM with registered memory command and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state     <= ST_BUSY_D;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            // read+write together is a store
            r_mem_write <= d_write;
            r_mem_read  <= ~d_write;
          end else if (w_grant_i) begin
            r_state     <= ST_BUSY_I;
            r_mem_addr  <= i_addr;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
          end
        end
        ST_BUSY_I: begin
          if (mem_ready) begin
            r_state    <= ST_IDLE;
            r_mem_read <= 1'b0;
            r_i_done   <= 1'b1;
            r_i_rdata  <= mem_rdata;
          end
        end
        ST_BUSY_D: begin
          if (mem_ready) begin
            r_state     <= ST_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_d_done    <= 1'b1;
            // stores leave the last load data untouched
            if (r_mem_read) begin
              r_d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive D grants taken while IF is requesting; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_grant_i) begin
      r_streak <= '0;
    end else if (w_idle && !i_req) begin
      r_streak <= '0;
    end else if (w_grant_d && i_req && (r_streak < STREAK_MAX)) begin
      r_streak <= r_streak + STREAK_W'(1);
    end
  end

`ifdef MEM_PORT_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] r_stat_i_grants;
  logic [STAT_W-1:0] r_stat_d_grants;
  logic [STAT_W-1:0] r_stat_conflicts;
  logic              w_conflict;

  // Both requesters competing in an arbitration cycle.
  assign w_conflict = w_idle & w_i_pend & w_d_pend;

  // Wrapping grant and conflict counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_i_grants  <= '0;
      r_stat_d_grants  <= '0;
      r_stat_conflicts <= '0;
    end else begin
      if (w_grant_i) begin
        r_stat_i_grants <= r_stat_i_grants + STAT_W'(1);
      end
      if (w_grant_d) begin
        r_stat_d_grants <= r_stat_d_grants + STAT_W'(1);
      end
      if (w_conflict) begin
        r_stat_conflicts <= r_stat_conflicts + STAT_W'(1);
      end
    end
  end

  assign stat_i_grants  = r_stat_i_grants;
  assign stat_d_grants  = r_stat_d_grants;
  assign stat_conflicts = r_stat_conflicts;
`endif

  assign i_done    = r_i_done;
  assign i_rdata   = r_i_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Stalls follow the live request and release in the done cycle.
  assign i_stall = i_req & ~r_i_done;
  assign d_stall = w_d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: a directed vector table, reset
// corner cases, and model-driven sequences (conflict, back-to-back loads with
// a waiting fetch, randomized traffic) checked against a transaction-level
// reference model. Define MEM_PORT_ARB_STATS_EN to also check the counters.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        i_stall;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0] stat_i_grants;
  logic [15:0] stat_d_grants;
  logic [15:0] stat_conflicts;
`endif

  mem_port_arbiter #(.WORD_SIZE(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .i_stall   (i_stall),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef MEM_PORT_ARB_STATS_EN
    ,
    .stat_i_grants  (stat_i_grants),
    .stat_d_grants  (stat_d_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------- table
  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_idone;
    logic        e_ddone;
    logic [15:0] e_irdata;
    logic [15:0] e_drdata;
    logic        e_istall;
    logic        e_dstall;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [15:0] ia, logic dr, logic dw,
                              logic [15:0] da, logic [15:0] dwd, logic rdy,
                              logic [15:0] rd, logic erd, logic ewr,
                              logic [15:0] ea, logic [15:0] ewd, logic eid,
                              logic edd, logic [15:0] eir, logic [15:0] edr,
                              logic eis, logic eds);
    vec_t v;
    v.i_req = ir;  v.i_addr = ia;  v.d_read = dr;  v.d_write = dw;
    v.d_addr = da; v.d_wdata = dwd; v.rdy = rdy;   v.rdata = rd;
    v.e_rd = erd;  v.e_wr = ewr;   v.e_addr = ea;  v.e_wdata = ewd;
    v.e_idone = eid; v.e_ddone = edd; v.e_irdata = eir; v.e_drdata = edr;
    v.e_istall = eis; v.e_dstall = eds;
    return v;
  endfunction

  // --------------------------------------------------------------- model
  int          m_own;      // 0 none, 1 IF, 2 MEM
  bit          m_new;
  bit          m_idone, m_ddone, m_rd, m_wr;
  logic [15:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_streak;
  logic [15:0] m_st_i, m_st_d, m_st_c;
  int          q_model[$];
  int          q_dut[$];
  bit          prev_cmd;
  int          resp_wait;
  int          g_mode;     // 1 single shot, 2 load burst, 3 random
  int          d_left;
  bit          i_stop;

  function automatic void model_reset();
    m_own = 0; m_new = 0; m_idone = 0; m_ddone = 0; m_rd = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_streak = 0;
    m_st_i = '0; m_st_d = '0; m_st_c = '0;
    q_model.delete(); q_dut.delete(); prev_cmd = 0; resp_wait = 0;
  endfunction

  // One clock edge of the arbiter's rules, using the inputs held before it.
  function automatic void model_edge();
    bit ip, dp, pick_i, pick_d, nid, ndd;
    nid = 0; ndd = 0; m_new = 0;
    if (m_own == 0) begin
      ip = i_req && !m_idone;
      dp = (d_read || d_write) && !m_ddone;
      pick_i = ip && (!dp || (LIMIT != 0 && m_streak == LIMIT));
      pick_d = dp && !pick_i;
      if (ip && dp) m_st_c++;
      if (pick_i) begin
        m_own = 1; m_addr = i_addr; m_rd = 1; m_wr = 0; m_streak = 0;
        m_st_i++; q_model.push_back(1); m_new = 1;
      end else if (pick_d) begin
        m_own = 2; m_addr = d_addr; m_wdata = d_wdata;
        m_wr = d_write; m_rd = !d_write;
        if (i_req && m_streak < LIMIT) m_streak++;
        m_st_d++; q_model.push_back(2); m_new = 1;
      end
      if (!i_req) m_streak = 0;
    end else if (mem_ready) begin
      if (m_own == 1) begin
        nid = 1; m_irdata = mem_rdata;
      end else begin
        ndd = 1;
        if (m_rd) m_drdata = mem_rdata;
      end
      m_own = 0; m_rd = 0; m_wr = 0;
    end
    m_idone = nid; m_ddone = ndd;
  endfunction

  task automatic check_regs();
    chk("mem_read", mem_read, m_rd);
    chk("mem_write", mem_write, m_wr);
    if (m_rd || m_wr) chk("mem_addr", mem_addr, m_addr);
    if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_done", i_done, m_idone);
    chk("d_done", d_done, m_ddone);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
`ifdef MEM_PORT_ARB_STATS_EN
    chk("stat_i_grants", stat_i_grants, m_st_i);
    chk("stat_d_grants", stat_d_grants, m_st_d);
    chk("stat_conflicts", stat_conflicts, m_st_c);
`endif
  endtask

  task automatic drive_agents();
    int r;
    case (g_mode)
      1: begin
        if (i_req && m_idone) i_req = 0;
        if ((d_read || d_write) && m_ddone) begin d_read = 0; d_write = 0; end
      end
      2: begin
        if (m_ddone) begin
          if (d_left > 0) begin d_left--; d_addr = d_addr + 16'h0010; end
          else begin d_read = 0; i_stop = 1; end
        end
        if (m_idone) begin
          if (i_stop) i_req = 0;
          else i_addr = i_addr + 16'h0002;
        end
      end
      3: begin
        if (i_req && m_idone) begin
          i_req = ($urandom_range(0, 1) == 1); i_addr = {1'b0, 15'($urandom)};
        end else if (!i_req) begin
          if ($urandom_range(0, 2) == 0) begin
            i_req = 1; i_addr = {1'b0, 15'($urandom)};
          end
        end else if ($urandom_range(0, 29) == 0) i_req = 0;
        if ((d_read || d_write) && !m_ddone && $urandom_range(0, 29) == 0) begin
          d_read = 0; d_write = 0;
        end else if (!(d_read || d_write) || m_ddone) begin
          if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 3);
            d_read = (r != 2); d_write = (r >= 2);
            d_addr = {1'b1, 15'($urandom)}; d_wdata = 16'($urandom);
          end else begin
            d_read = 0; d_write = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Memory responder: ready 0..2 cycles after the command appears.
  task automatic drive_mem();
    if (m_own != 0) begin
      if (m_new) resp_wait = $urandom_range(0, 2);
      mem_ready = (resp_wait == 0);
      if (resp_wait > 0) resp_wait--;
      mem_rdata = mem_ready ? (m_addr ^ 16'h5AC3) : 16'($urandom);
    end else begin
      mem_ready = (g_mode == 3) && ($urandom_range(0, 9) == 0);
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic run_cycle();
    bit cmd;
    @(posedge clk); #1;
    model_edge();
    check_regs();
    cmd = mem_read | mem_write;
    if (cmd && !prev_cmd) q_dut.push_back(mem_addr[15] ? 2 : 1);
    prev_cmd = cmd;
    drive_agents();
    drive_mem();
    #1;
    chk("i_stall", i_stall, i_req & ~m_idone);
    chk("d_stall", d_stall, (d_read | d_write) & ~m_ddone);
  endtask

  task automatic run_until_quiet(string name, int budget);
    int n;
    n = 0;
    while (!(m_own == 0 && !i_req && !d_read && !d_write && !m_idone && !m_ddone)) begin
      if (n >= budget) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout: got busy after %0d cycles want idle", name, n);
        break;
      end
      run_cycle();
      n++;
    end
  endtask

  task automatic cmp_grants(string name);
    chk({name, "_grant_count"}, 16'(q_dut.size()), 16'(q_model.size()));
    for (int k = 0; k < q_model.size() && k < q_dut.size(); k++)
      chk($sformatf("%s_grant%0d", name, k), 16'(q_dut[k]), 16'(q_model[k]));
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
    d_wdata = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  // ---------------------------------------------------------------- main
  vec_t vtab[18];
  int   d_cnt;

  initial begin
    g_mode = 0; d_left = 0; i_stop = 0;
    model_reset();

    vtab[0]  = mk(1,16'h0010,0,0,16'h0000,16'h0000,0,16'h0000, 1,0,16'h0010,16'h0000,0,0,16'h0000,16'h0000,1,0);
    vtab[1]  = vtab[0];
    vtab[2]  = vtab[0];
    vtab[3]  = mk(1,16'h0010,0,0,16'h0000,16'h0000,1,16'h1234, 0,0,16'h0000,16'h0000,1,0,16'h1234,16'h0000,0,0);
    vtab[4]  = mk(0,16'h0010,0,0,16'h0000,16'h0000,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,16'h1234,16'h0000,0,0);
    vtab[5]  = mk(0,16'h0000,0,1,16'h0020,16'hBEEF,0,16'h0000, 0,1,16'h0020,16'hBEEF,0,0,16'h1234,16'h0000,0,1);
    vtab[6]  = vtab[5];
    vtab[7]  = mk(0,16'h0000,0,1,16'h0020,16'hBEEF,1,16'h5555, 0,0,16'h0000,16'h0000,0,1,16'h1234,16'h0000,0,0);
    vtab[8]  = mk(0,16'h0000,0,0,16'h0020,16'hBEEF,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,16'h1234,16'h0000,0,0);
    vtab[9]  = mk(1,16'h0040,1,0,16'h0100,16'h0000,0,16'h0000, 1,0,16'h0100,16'h0000,0,0,16'h1234,16'h0000,1,1);
    vtab[10] = mk(1,16'h0040,1,0,16'h0100,16'h0000,1,16'hD00D, 0,0,16'h0000,16'h0000,0,1,16'h1234,16'hD00D,1,0);
    vtab[11] = mk(1,16'h0040,0,0,16'h0100,16'h0000,0,16'h0000, 1,0,16'h0040,16'h0000,0,0,16'h1234,16'hD00D,1,0);
    vtab[12] = mk(1,16'h0040,0,0,16'h0100,16'h0000,1,16'hCAFE, 0,0,16'h0000,16'h0000,1,0,16'hCAFE,16'hD00D,0,0);
    vtab[13] = mk(0,16'h0040,0,0,16'h0100,16'h0000,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,16'hCAFE,16'hD00D,0,0);
    vtab[14] = mk(0,16'h0040,0,0,16'h0100,16'h0000,1,16'h7777, 0,0,16'h0000,16'h0000,0,0,16'hCAFE,16'hD00D,0,0);
    vtab[15] = mk(0,16'h0000,1,1,16'h0030,16'h1111,0,16'h0000, 0,1,16'h0030,16'h1111,0,0,16'hCAFE,16'hD00D,0,1);
    vtab[16] = mk(0,16'h0000,1,1,16'h0030,16'h1111,1,16'h9999, 0,0,16'h0000,16'h0000,0,1,16'hCAFE,16'hD00D,0,0);
    vtab[17] = mk(0,16'h0000,0,0,16'h0030,16'h1111,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,16'hCAFE,16'hD00D,0,0);

    // Reset state
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_i_done", i_done, 1'b0);
    chk("rst_d_done", d_done, 1'b0);
    chk("rst_i_rdata", i_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    chk("rst_i_stall", i_stall, 1'b0);
    chk("rst_d_stall", d_stall, 1'b0);
`ifdef MEM_PORT_ARB_STATS_EN
    chk("rst_stat_i", stat_i_grants, 16'h0000);
    chk("rst_stat_d", stat_d_grants, 16'h0000);
    chk("rst_stat_c", stat_conflicts, 16'h0000);
`endif
    reset = 0;

    // Directed vectors: fetch, store, conflict, stray ready, read+write
    for (int k = 0; k < 18; k++) begin
      i_req = vtab[k].i_req; i_addr = vtab[k].i_addr;
      d_read = vtab[k].d_read; d_write = vtab[k].d_write;
      d_addr = vtab[k].d_addr; d_wdata = vtab[k].d_wdata;
      mem_ready = vtab[k].rdy; mem_rdata = vtab[k].rdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_read", k), mem_read, vtab[k].e_rd);
      chk($sformatf("v%0d_mem_write", k), mem_write, vtab[k].e_wr);
      if (vtab[k].e_rd || vtab[k].e_wr)
        chk($sformatf("v%0d_mem_addr", k), mem_addr, vtab[k].e_addr);
      if (vtab[k].e_wr)
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vtab[k].e_wdata);
      chk($sformatf("v%0d_i_done", k), i_done, vtab[k].e_idone);
      chk($sformatf("v%0d_d_done", k), d_done, vtab[k].e_ddone);
      chk($sformatf("v%0d_i_rdata", k), i_rdata, vtab[k].e_irdata);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, vtab[k].e_drdata);
      chk($sformatf("v%0d_i_stall", k), i_stall, vtab[k].e_istall);
      chk($sformatf("v%0d_d_stall", k), d_stall, vtab[k].e_dstall);
    end
    clear_inputs();

    // Reset in the middle of a load, then a stale mem_ready
    d_read = 1; d_addr = 16'h0200;
    @(posedge clk); #1;
    chk("rb_busy_read", mem_read, 1'b1);
    chk("rb_busy_addr", mem_addr, 16'h0200);
    #2 reset = 1;
    #1;
    chk("rb_async_mem_read", mem_read, 1'b0);
    chk("rb_async_d_done", d_done, 1'b0);
    chk("rb_async_d_rdata", d_rdata, 16'h0000);
    d_read = 0;
    @(posedge clk); #1;
    reset = 0;
    mem_ready = 1; mem_rdata = 16'hABCD;
    @(posedge clk); #1;
    chk("rb_stale_d_done", d_done, 1'b0);
    chk("rb_stale_i_done", i_done, 1'b0);
    chk("rb_stale_mem_read", mem_read, 1'b0);
    chk("rb_stale_d_rdata", d_rdata, 16'h0000);
    mem_ready = 0;
    d_read = 1; d_addr = 16'h0210;
    @(posedge clk); #1;
    chk("rb_after_read", mem_read, 1'b1);
    chk("rb_after_addr", mem_addr, 16'h0210);
    mem_ready = 1; mem_rdata = 16'h4321;
    @(posedge clk); #1;
    chk("rb_after_d_done", d_done, 1'b1);
    chk("rb_after_d_rdata", d_rdata, 16'h4321);
    clear_inputs();

    // Model-checked conflict: both requesters rise together
    do_reset();
    g_mode = 1;
    i_req = 1; i_addr = 16'h0040; d_read = 1; d_addr = 16'h8100;
    run_until_quiet("conflict", 50);
    cmp_grants("conflict");
`ifdef MEM_PORT_ARB_STATS_EN
    chk("conflict_stat_i", stat_i_grants, 16'd1);
    chk("conflict_stat_d", stat_d_grants, 16'd1);
    chk("conflict_stat_c", stat_conflicts, 16'd1);
`endif

    // Five back-to-back loads while a fetch is held
    do_reset();
    g_mode = 2; d_left = 4; i_stop = 0;
    i_req = 1; i_addr = 16'h0300; d_read = 1; d_addr = 16'h8400;
    run_until_quiet("burst", 200);
    cmp_grants("burst");
    d_cnt = 0;
    foreach (q_dut[k]) if (q_dut[k] == 2) d_cnt++;
    chk("burst_d_grants", 16'(d_cnt), 16'd5);

    // Randomized traffic with flushes, stray readies and mixed ops
    do_reset();
    g_mode = 3;
    repeat (3000) run_cycle();
    g_mode = 1;
    run_until_quiet("random", 50);
    cmp_grants("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
